// File: rtl/queue_pre_decode.sv
// Instruction byte queue with x86-style prefix collection and opcode pre-decode.
// Latency: a byte pushed in cycle N can be presented as op_valid in cycle N+2.
// Backpressure: push_ready drops when fewer than PUSH_BYTES slots are free; the op is held until op_ready.
//
// Ports:
//   clk, reset (sync, active-high), ce (clock enable), flush (discard everything)
//   push_valid/push_data/push_count/push_ready : byte producer side, byte 0 oldest
//   q_len                                      : current byte occupancy
//   op_valid/op_ready/decoded                  : presented instruction and its pre-decode record
//   seg_valid/seg, rep, lock                   : prefixes collected ahead of the presented opcode

package queue_pre_decode_pkg;
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] modrm;      // zero when the opcode has no ModRM byte
    logic       has_modrm;
    logic [2:0] pre_size;   // total bytes of opcode + ModRM + displacement/immediate
  } pre_decode_t;
endpackage

module queue_pre_decode
  import queue_pre_decode_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int PUSH_BYTES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ce,
  input  logic                            flush,
  input  logic                            push_valid,
  input  logic [8*PUSH_BYTES-1:0]         push_data,
  input  logic [$clog2(PUSH_BYTES):0]     push_count,
  output logic                            push_ready,
  output logic [$clog2(DEPTH):0]          q_len,
  output logic                            op_valid,
  input  logic                            op_ready,
  output pre_decode_t                     decoded,
  output logic                            seg_valid,
  output logic [1:0]                      seg,
  output logic [1:0]                      rep,
  output logic                            lock
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(PUSH_BYTES) + 1;

  typedef enum logic {SCAN, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [7:0]      mem [DEPTH];

  logic [7:0]      q0, q1;
  logic            is_seg, is_rep, is_lock;
  logic            do_push;
  logic [LW-1:0]   push_n, pop_n;
  pre_decode_t     dec;

  // Opcode length table. Only the opcode and ModRM bytes affect the length of
  // the 16-bit forms covered here; the immediate/displacement bytes don't.
  function automatic pre_decode_t decode_op(input logic [7:0] b0, input logic [7:0] b1);
    pre_decode_t d;
    d.opcode    = b0;
    d.modrm     = 8'h00;
    d.has_modrm = 1'b0;
    d.pre_size  = 3'd1;
    casez (b0)
      8'b00??_?0??: d.has_modrm = 1'b1;  // ALU r/m,reg forms
      8'b00??_?100: d.pre_size  = 3'd2;  // ALU AL,imm8
      8'b00??_?101: d.pre_size  = 3'd3;  // ALU AX,imm16
      8'b1000_10??: d.has_modrm = 1'b1;  // MOV r/m,reg forms
      8'b0111_????: d.pre_size  = 3'd2;  // Jcc rel8
      8'b1011_0???: d.pre_size  = 3'd2;  // MOV r8,imm8
      8'b1011_1???: d.pre_size  = 3'd3;  // MOV r16,imm16
      8'b1110_100?: d.pre_size  = 3'd3;  // CALL/JMP rel16
      8'hEB:        d.pre_size  = 3'd2;  // JMP rel8
      8'hCD:        d.pre_size  = 3'd2;  // INT imm8
      default:      d.pre_size  = 3'd1;
    endcase
    if (d.has_modrm) begin
      d.modrm = b1;
      case (b1[7:6])
        2'b01:   d.pre_size = 3'd3;
        2'b10:   d.pre_size = 3'd4;
        2'b00:   d.pre_size = (b1[2:0] == 3'b110) ? 3'd4 : 3'd2;  // direct address disp16
        default: d.pre_size = 3'd2;
      endcase
    end
    return d;
  endfunction

  always_comb begin
    // Bytes past the occupancy read as zero so a partial opcode never sees stale data.
    q0 = (q_len >= LW'(1)) ? mem[head] : 8'h00;
    q1 = (q_len >= LW'(2)) ? mem[head + PW'(1)] : 8'h00;

    is_seg  = (q0 == 8'h26) || (q0 == 8'h2E) || (q0 == 8'h36) || (q0 == 8'h3E);
    is_rep  = (q0 == 8'hF2) || (q0 == 8'hF3);
    is_lock = (q0 == 8'hF0);
    dec     = decode_op(q0, q1);

    push_ready = (LW'(DEPTH) - q_len) >= LW'(PUSH_BYTES);
    do_push    = push_valid && push_ready;
    push_n     = do_push ? LW'(push_count) : '0;

    pop_n = '0;
    if (state == SCAN) begin
      if (q_len != '0 && (is_seg || is_rep || is_lock)) pop_n = LW'(1);
    end else if (op_ready) begin
      pop_n = LW'(decoded.pre_size);
    end
  end

  assign op_valid = (state == HOLD);

  // Byte storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && ce && !flush && do_push) begin
      for (int i = 0; i < PUSH_BYTES; i++) begin
        if (CW'(i) < push_count) mem[tail + PW'(i)] <= push_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      head      <= '0;
      tail      <= '0;
      q_len     <= '0;
      decoded   <= '0;
      seg_valid <= 1'b0;
      seg       <= 2'd0;
      rep       <= 2'd0;
      lock      <= 1'b0;
    end else if (ce) begin
      if (flush) begin
        state     <= SCAN;
        head      <= '0;
        tail      <= '0;
        q_len     <= '0;
        decoded   <= '0;
        seg_valid <= 1'b0;
        seg       <= 2'd0;
        rep       <= 2'd0;
        lock      <= 1'b0;
      end else begin
        head  <= head + PW'(pop_n);
        tail  <= tail + PW'(push_n);
        q_len <= q_len + push_n - pop_n;
        case (state)
          SCAN: begin
            if (q_len != '0) begin
              if (is_seg) begin
                seg_valid <= 1'b1;
                seg       <= q0[4:3];         // 26/2E/36/3E -> ES/CS/SS/DS
              end else if (is_rep) begin
                rep <= {1'b1, q0[0]};         // F2 -> 2, F3 -> 3
              end else if (is_lock) begin
                lock <= 1'b1;
              end else if (q_len >= LW'(dec.pre_size)) begin
                decoded <= dec;
                state   <= HOLD;
              end
            end
          end
          HOLD: begin
            if (op_ready) begin
              seg_valid <= 1'b0;
              seg       <= 2'd0;
              rep       <= 2'd0;
              lock      <= 1'b0;
              state     <= SCAN;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
